// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one 8x8 unsigned shift-add multiplier between
// two requesters; eight RUN iterations per product, one-cycle done strobe.
module mult_rr_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic        req1,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        done,
  output logic        owner,
  output logic [15:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] result_q, result_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_owner_q, last_owner_d;
  logic        owner_q, owner_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept;
  logic        sel;
  logic [8:0]  sum;

  // State and datapath registers; reset wins over every other update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mcand_q      <= 8'd0;
      mplier_q     <= 8'd0;
      acc_q        <= 16'd0;
      result_q     <= 16'd0;
      cnt_q        <= 3'd0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      result_q     <= result_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Arbitration: on a tie the requester that was not served last wins
  always_comb begin
    accept = 1'b0;
    sel    = 1'b0;
    if (state_q == S_IDLE) begin
      accept = req0 | req1;
      if (req0 && req1) begin
        sel = ~last_owner_q;
      end else if (req1) begin
        sel = 1'b1;
      end else begin
        sel = 1'b0;
      end
    end else begin
      accept = 1'b0;
      sel    = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept ? S_RUN : S_IDLE;
      S_RUN:   state_d = (cnt_q == 3'd7) ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one shift-add step per RUN cycle
  always_comb begin
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    result_d     = result_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    sum          = {1'b0, acc_q[15:8]} + (mplier_q[0] ? {1'b0, mcand_q} : 9'd0);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mcand_d      = sel ? a1 : a0;
          mplier_d     = sel ? b1 : b0;
          acc_d        = 16'd0;
          cnt_d        = 3'd0;
          owner_d      = sel;
          last_owner_d = sel;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        // carry out of the add lands in bit 15 as the accumulator shifts right
        acc_d    = {sum, acc_q[7:1]};
        mplier_d = {1'b0, mplier_q[7:1]};
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          result_d = {sum, acc_q[7:1]};
        end else begin
          result_d = result_q;
        end
      end
      S_DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Output strobes computed one cycle ahead so every output is a flop
  always_comb begin
    gnt0_d = accept & ~sel;
    gnt1_d = accept & sel;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign owner  = owner_q;
  assign result = result_q;

endmodule
